// File: rtl/alu_mem_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: ALU opcode values,
// the sequencer FSM state encoding and a small opcode helper.
package alu_mem_seq_pkg;

    localparam int OP_W = 5;

    // Opcodes understood by the ALU; any other value is forwarded as-is.
    typedef enum logic [OP_W-1:0] {
        A_NOP = 5'h00,
        A_ADD = 5'h01,
        A_SUB = 5'h02,
        A_AND = 5'h03,
        A_OR  = 5'h04,
        A_XOR = 5'h05,
        A_NOR = 5'h06
    } alu_opcode_e;

    // Sequencer states, one RAM access per state at most.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } seq_state_e;

    // NOP commands skip the write-back cycle entirely.
    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return op == A_NOP;
    endfunction

endpackage

// File: rtl/alu_mem_seq_if.sv
// Bundle of the command, RAM-port and ALU-port signals of the sequencer.
// The sequencer uses the slave view; its environment uses the master view.
interface alu_mem_seq_if
    import alu_mem_seq_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // command side
    logic              start;
    logic [OP_W-1:0]   op_in;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_d;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    // single-port RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // ALU side
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_out;

    modport slave (
        input  start, op_in, addr_a, addr_b, addr_d, ram_rdata, alu_out,
        output busy, done, result, ram_addr, ram_we, ram_wdata, alu_a, alu_b, alu_op
    );

    modport master (
        output start, op_in, addr_a, addr_b, addr_d, ram_rdata, alu_out,
        input  busy, done, result, ram_addr, ram_we, ram_wdata, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/alu_mem_seq.sv
// Operand sequencer in front of the combinational ALU: reads A and B from a
// single-port synchronous RAM, presents them with the opcode to the ALU, writes
// the ALU result back to RAM and pulses done. One command at a time.
module alu_mem_seq
    import alu_mem_seq_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mem_seq_if.slave  bus
);

    seq_state_e        state_reg;
    seq_state_e        state_next;

    logic [OP_W-1:0]   op_reg;
    logic [ADDR_W-1:0] addr_a_reg;
    logic [ADDR_W-1:0] addr_b_reg;
    logic [ADDR_W-1:0] addr_d_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic [DATA_W-1:0] result_reg;

    logic [ADDR_W-1:0] ram_addr_next;
    logic              ram_we_next;
    logic [DATA_W-1:0] ram_wdata_next;

    // State register; reset drops straight back to IDLE, so a pending write is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fixed walk through the read, execute and write-back steps.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_RD_A;
            S_RD_A:  state_next = S_RD_B;
            S_RD_B:  state_next = S_EXEC;
            S_EXEC:  state_next = is_nop(op_reg) ? S_DONE : S_WB;
            S_WB:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers: command latch, ALU operand capture and result capture.
    // RAM read data arrives one state after its address, hence A is taken in
    // RD_B and B in EXEC; the ALU sees a full operand set during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= '0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            addr_d_reg <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        op_reg     <= bus.op_in;
                        addr_a_reg <= bus.addr_a;
                        addr_b_reg <= bus.addr_b;
                        addr_d_reg <= bus.addr_d;
                    end
                end
                S_RD_B: begin
                    alu_a_reg  <= bus.ram_rdata;
                    alu_op_reg <= op_reg;
                end
                S_EXEC: begin
                    alu_b_reg <= bus.ram_rdata;
                    if (is_nop(op_reg)) begin
                        result_reg <= '0;
                    end
                end
                S_WB: begin
                    result_reg <= bus.alu_out;
                end
                default: begin
                end
            endcase
        end
    end

    // RAM port muxing: address follows the state, write only during WB.
    always_comb begin
        ram_addr_next  = '0;
        ram_we_next    = 1'b0;
        ram_wdata_next = '0;
        case (state_reg)
            S_RD_A: ram_addr_next = addr_a_reg;
            S_RD_B: ram_addr_next = addr_b_reg;
            S_WB: begin
                ram_addr_next  = addr_d_reg;
                ram_we_next    = 1'b1;
                ram_wdata_next = bus.alu_out;
            end
            default: begin
            end
        endcase
    end

    assign bus.ram_addr  = ram_addr_next;
    assign bus.ram_we    = ram_we_next;
    assign bus.ram_wdata = ram_wdata_next;
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.result    = result_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_op    = alu_op_reg;

endmodule

// File: tb/tb_alu_mem_seq.sv
// Bench for alu_mem_seq: provides a synchronous single-port RAM and the
// combinational ALU around the sequencer, then runs a vector table, random
// commands against a memory-image reference, and reset/busy corner cases.
module tb_alu_mem_seq;
    import alu_mem_seq_pkg::*;

    logic clk;
    logic rst_n;

    alu_mem_seq_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    alu_mem_seq #(.ADDR_W(6), .DATA_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Expected ALU behaviour from the opcode list; unknown opcodes give 0.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'h01:   return a + b;
            5'h02:   return a - b;
            5'h03:   return a & b;
            5'h04:   return a | b;
            5'h05:   return a ^ b;
            5'h06:   return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    // Environment ALU.
    assign bus.alu_out = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

    // Environment RAM, with a bench-only preload port.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic mem_cmp(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(name, bad, 0);
    endtask

    // Issue one command and observe 8 cycles; lat counts cycles after the
    // start-sampling edge up to and including the done cycle.
    task automatic run_cmd(input logic [4:0] op, input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] d, input bit hammer,
                           output int lat, output int we_cnt, output int done_cnt, output bit addr_ok);
        lat = 0; we_cnt = 0; done_cnt = 0; addr_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.op_in = op;
        bus.addr_a = a; bus.addr_b = b; bus.addr_d = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_in = 5'($urandom_range(1, 6));
        bus.addr_a = 6'($urandom); bus.addr_b = 6'($urandom); bus.addr_d = 6'($urandom);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (hammer) bus.start = bus.busy;
            if (bus.ram_we) we_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (lat == 0) lat = n;
                if (bus.ram_addr != 6'd0 || !bus.busy) addr_ok = 1'b0;
            end
            if (!bus.busy && bus.ram_addr != 6'd0) addr_ok = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [5:0]  a, b, d;
        logic [31:0] va, vb, exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, we_cnt, done_cnt, found;
        bit addr_ok;
        logic [31:0] exp;
        logic [4:0] op;
        logic [5:0] a, b, d;
        bit nop;

        vecs[0] = '{5'h01, 6'd1,  6'd2,  6'd3,  32'd5,         32'd3,         32'd8};
        vecs[1] = '{5'h02, 6'd1,  6'd2,  6'd4,  32'd3,         32'd5,         32'hFFFF_FFFE};
        vecs[2] = '{5'h01, 6'd5,  6'd6,  6'd7,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
        vecs[3] = '{5'h06, 6'd1,  6'd2,  6'd1,  32'd0,         32'd0,         32'hFFFF_FFFF};
        vecs[4] = '{5'h00, 6'd8,  6'd9,  6'd10, 32'd11,        32'd22,        32'd0};
        vecs[5] = '{5'h03, 6'd11, 6'd12, 6'd13, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[6] = '{5'h04, 6'd14, 6'd15, 6'd16, 32'h0000_FF00, 32'h00FF_0000, 32'h00FF_FF00};
        vecs[7] = '{5'h05, 6'd17, 6'd18, 6'd19, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[8] = '{5'h1F, 6'd20, 6'd21, 6'd22, 32'd7,         32'd9,         32'd0};
        vecs[9] = '{5'h05, 6'd23, 6'd24, 6'd24, 32'd1,         32'd3,         32'd2};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_in = '0;
        bus.addr_a = '0; bus.addr_b = '0; bus.addr_d = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_result", bus.result, 0);

        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            nop = (vecs[i].op == 5'h00);
            poke(vecs[i].a, vecs[i].va);
            poke(vecs[i].b, vecs[i].vb);
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, 1'b0, lat, we_cnt, done_cnt, addr_ok);
            if (!nop) ref_mem[vecs[i].d] = vecs[i].exp;
            $display("vec %0d op=%h a=%0d b=%0d d=%0d result=%h lat=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, vecs[i].d, bus.result, lat);
            chk($sformatf("vec%0d_latency", i), lat, nop ? 4 : 5);
            chk($sformatf("vec%0d_we_pulses", i), we_cnt, nop ? 0 : 1);
            chk($sformatf("vec%0d_done_pulses", i), done_cnt, 1);
            chk($sformatf("vec%0d_addr_idle_done", i), addr_ok, 1);
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
            if (!nop) chk($sformatf("vec%0d_mem_d", i), mem[vecs[i].d], vecs[i].exp);
            mem_cmp($sformatf("vec%0d_mem_image", i));
        end

        // Random commands against the memory-image reference.
        for (int i = 0; i < 30; i++) begin
            op = 5'($urandom_range(0, 7));
            a = 6'($urandom); b = 6'($urandom); d = 6'($urandom);
            exp = ref_alu(op, ref_mem[a], ref_mem[b]);
            run_cmd(op, a, b, d, 1'b0, lat, we_cnt, done_cnt, addr_ok);
            if (op != 5'h00) ref_mem[d] = exp;
            $display("rnd %0d op=%h a=%0d b=%0d d=%0d result=%h lat=%0d", i, op, a, b, d, bus.result, lat);
            chk($sformatf("rnd%0d_latency", i), lat, (op == 5'h00) ? 4 : 5);
            chk($sformatf("rnd%0d_result", i), bus.result, exp);
            mem_cmp($sformatf("rnd%0d_mem_image", i));
        end

        // start held high through the whole busy period: only one command runs.
        poke(6'd30, 32'd100);
        poke(6'd31, 32'd23);
        run_cmd(5'h01, 6'd30, 6'd31, 6'd32, 1'b1, lat, we_cnt, done_cnt, addr_ok);
        ref_mem[32] = 32'd123;
        $display("hammer result=%h we=%0d done=%0d", bus.result, we_cnt, done_cnt);
        chk("hammer_we_pulses", we_cnt, 1);
        chk("hammer_done_pulses", done_cnt, 1);
        chk("hammer_result", bus.result, 32'd123);
        mem_cmp("hammer_mem_image");
        run_cmd(5'h02, 6'd30, 6'd31, 6'd33, 1'b0, lat, we_cnt, done_cnt, addr_ok);
        ref_mem[33] = 32'd77;
        $display("after_hammer result=%h lat=%0d", bus.result, lat);
        chk("after_hammer_latency", lat, 5);
        chk("after_hammer_result", bus.result, 32'd77);

        // Reset asserted in the write-back cycle.
        poke(6'd40, 32'd4);
        poke(6'd41, 32'd6);
        @(negedge clk);
        bus.start = 1'b1; bus.op_in = 5'h01;
        bus.addr_a = 6'd40; bus.addr_b = 6'd41; bus.addr_d = 6'd42;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        found = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                found = 1;
                break;
            end
        end
        chk("rstwb_reached_wb", found, 1);
        #1;
        rst_n = 1'b0;
        #1;
        $display("reset in WB: ram_we=%b busy=%b done=%b result=%h", bus.ram_we, bus.busy, bus.done, bus.result);
        chk("rstwb_ram_we", bus.ram_we, 0);
        chk("rstwb_busy", bus.busy, 0);
        chk("rstwb_result", bus.result, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        chk("rstwb_no_done", done_cnt, 0);
        chk("rstwb_mem_d_kept", mem[42], ref_mem[42]);
        mem_cmp("rstwb_mem_image");
        run_cmd(5'h01, 6'd40, 6'd41, 6'd42, 1'b0, lat, we_cnt, done_cnt, addr_ok);
        ref_mem[42] = 32'd10;
        $display("after_reset result=%h lat=%0d", bus.result, lat);
        chk("after_rst_latency", lat, 5);
        chk("after_rst_result", bus.result, 32'd10);
        chk("after_rst_mem_d", mem[42], 32'd10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
